// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - reduction stage summing NUM_TERMS adder results
//
// Purpose:
//   Accepts adder results (in_sum, in_carry) over a valid/ready handshake,
//   adds NUM_TERMS of them into a wide accumulator, then holds the total
//   together with sticky overflow / any-carry flags on a valid/ready output.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  upstream handshake; in_ready is combinational
//   in_sum          WIDTH+1 bit adder sum (MSB is the adder carry-out)
//   in_carry        adder carry flag, ORed into out_any_carry, never added
//   clear           synchronous abort of the current reduction
//   out_valid/ready downstream handshake
//   out_total       sum of NUM_TERMS in_sum values modulo 2^ACC_WIDTH
//   out_overflow    sticky: the accumulation wrapped past 2^ACC_WIDTH
//   out_any_carry   sticky: in_carry was set on some accepted term
module adder_result_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_sum,
  input  logic                 in_carry,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic                 out_overflow,
  output logic                 out_any_carry
);

  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 any_carry;

  logic                 accept;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 ovf_next;
  logic                 any_carry_next;

  // Ready depends on rst_n directly so it drops the instant reset asserts,
  // not at the next edge.
  assign in_ready = rst_n && !clear && (state != S_DONE);
  assign accept   = in_valid && in_ready;

  // One extra bit captures the carry out of the accumulator width.
  assign sum_wide       = {1'b0, acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, in_sum};
  assign ovf_next       = ovf | sum_wide[ACC_WIDTH];
  assign any_carry_next = any_carry | in_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      any_carry     <= 1'b0;
      out_total     <= '0;
      out_overflow  <= 1'b0;
      out_any_carry <= 1'b0;
      out_valid     <= 1'b0;
    end else if (clear) begin
      // Clear wins over a same-cycle output handshake; a held result is dropped.
      state         <= S_IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      any_carry     <= 1'b0;
      out_overflow  <= 1'b0;
      out_any_carry <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc       <= sum_wide[ACC_WIDTH-1:0];
            ovf       <= ovf_next;
            any_carry <= any_carry_next;
            cnt       <= cnt + CW'(1);
            if (cnt == LAST_IDX) begin
              state         <= S_DONE;
              out_total     <= sum_wide[ACC_WIDTH-1:0];
              out_overflow  <= ovf_next;
              out_any_carry <= any_carry_next;
              out_valid     <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state         <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            any_carry     <= 1'b0;
            out_overflow  <= 1'b0;
            out_any_carry <= 1'b0;
            out_valid     <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
